mdr_mem_if: RTL

- Memory-side feeder of the processor bus. Holds MAR and MDR, runs the single-outstanding read/write handshake with memory, and drives the MDR value onto the bus mux MDR input.
- The control sequencer pulses load/start strobes and waits on done.
- Bus value arrives on BusMuxOut. MDR content leaves on BusMuxInMDR.

---
 rtl/mdr_mem_if_if.sv | 31 +++
 rtl/mdr_mem_if.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mdr_mem_if_if.sv
// ---------------------------------------------------------------------------
// mdr_mem_if_if
// Memory-side handshake bundle used by mdr_mem_if.
//   mem_req   : request, held until ack or abort (master -> memory)
//   mem_we    : 1 = write, meaningful only while mem_req is high
//   mem_addr  : word address (ADDR_W bits), mirrors MAR
//   mem_wdata : write data, mirrors MDR
//   mem_rdata : read data, valid only together with mem_ack (memory -> master)
//   mem_ack   : one-cycle completion strobe (memory -> master)
// Modports: master (the MAR/MDR block), slave (the memory model).
// ---------------------------------------------------------------------------
interface mdr_mem_if_if #(
    parameter int ADDR_W = 9
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mdr_mem_if.sv
// ---------------------------------------------------------------------------
// mdr_mem_if
// Holds MAR and MDR for the processor bus and runs a single-outstanding
// read/write handshake with memory.
//   clock, clear       : clock and synchronous active-high reset
//   BusMuxOut          : bus value loaded into MAR (low ADDR_W bits) / MDR
//   MARin, MDRin       : load strobes (honoured only in IDLE)
//   rd_start, wr_start : one-cycle start pulses (read wins if both)
//   BusMuxInMDR        : MDR contents, always driven
//   busy, done, err    : status; done pulses for one cycle, err with done
//   mem                : memory handshake bundle (master side)
// Optional feature macro: MEM_TIMEOUT_EN. When defined, a wait longer than
// TIMEOUT cycles without ack aborts the transaction with err=1. When not
// defined the block waits for ack indefinitely and err is tied low.
// ---------------------------------------------------------------------------
module mdr_mem_if #(
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 16
) (
    input  logic         clock,
    input  logic         clear,
    input  logic [31:0]  BusMuxOut,
    input  logic         MARin,
    input  logic         MDRin,
    input  logic         rd_start,
    input  logic         wr_start,
    output logic [31:0]  BusMuxInMDR,
    output logic         busy,
    output logic         done,
    output logic         err,
    mdr_mem_if_if.master mem
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
        $error("mdr_mem_if: TIMEOUT must lie in 2..255");
    end

    state_t            state_q;
    logic [ADDR_W-1:0] mar_q;
    logic [31:0]       mdr_q;
    logic              req_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;

`ifdef MEM_TIMEOUT_EN
    // Last counter value before abort: wait cycles 1..TIMEOUT see 0..TIMEOUT-1.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q;
    logic       err_q;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Loads land on the same edge as a start, so the
                    // transaction sees the freshly loaded MAR/MDR.
                    if (MARin) mar_q <= BusMuxOut[ADDR_W-1:0];
                    if (MDRin) mdr_q <= BusMuxOut;
                    if (rd_start) begin
                        state_q <= S_RD_WAIT;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                        cnt_q   <= 8'd0;
`endif
                    end else if (wr_start) begin
                        state_q <= S_WR_WAIT;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        busy_q  <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                        cnt_q   <= 8'd0;
`endif
                    end
                end

                S_RD_WAIT, S_WR_WAIT: begin
                    if (mem.mem_ack) begin
                        if (state_q == S_RD_WAIT) mdr_q <= mem.mem_rdata;
                        state_q <= S_DONE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
`ifdef MEM_TIMEOUT_EN
                        err_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        // Abort: MAR/MDR untouched, report through err.
                        state_q <= S_DONE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
`endif
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BusMuxInMDR   = mdr_q;
    assign mem.mem_addr  = mar_q;
    assign mem.mem_wdata = mdr_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign busy          = busy_q;
    assign done          = done_q;
`ifdef MEM_TIMEOUT_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif
endmodule
